// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I immediate generator with a result FIFO.
// Option: define IMMGEN_UTYPE_EN to decode lui/auipc as U-type.
//
// Ports:
//   clk, reset             rising clock, sync active-high reset
//   in_valid/in_ready      instruction handshake (ready registered)
//   in_instr[31:0]         instruction word
//   out_valid/out_ready    result handshake (valid = !empty)
//   out_imm[XLEN-1:0]      sign-extended immediate of head entry
//   out_fmt[2:0]           0=I 1=S 2=B 3=U 4=J 7=none
//   out_noimm              head instruction has no immediate
//   noimm_cnt[CNTW-1:0]    saturating count of no-imm pushes
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_noimm,
  output logic [CNTW-1:0] noimm_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            noimm;
  } ent_t;

  ent_t            mem [DEPTH];
  ent_t            dec;
  ent_t            head;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     cnt;
  logic [AW:0]     cnt_nxt;
  logic            push;
  logic            pop;

  logic [6:0]         op;
  logic [31:0]        i;
  logic signed [31:0] imm32;
  logic is_i, is_s, is_b, is_j, is_u;

  assign i  = in_instr;
  assign op = in_instr[6:0];

  assign is_i = (op == 7'b0000011) ||
                (op == 7'b0010011) ||
                (op == 7'b1100111);
  assign is_s = (op == 7'b0100011);
  assign is_b = (op == 7'b1100011);
  assign is_j = (op == 7'b1101111);
`ifdef IMMGEN_UTYPE_EN
  assign is_u = (op == 7'b0110111) ||
                (op == 7'b0010111);
`else
  assign is_u = 1'b0;
`endif

  always_comb begin
    imm32     = '0;
    dec       = '0;
    dec.fmt   = 3'd7;
    dec.noimm = 1'b1;
    unique case (1'b1)
      is_i: begin
        imm32     = {{20{i[31]}}, i[31:20]};
        dec.fmt   = 3'd0;
        dec.noimm = 1'b0;
      end
      is_s: begin
        imm32     = {{20{i[31]}}, i[31:25], i[11:7]};
        dec.fmt   = 3'd1;
        dec.noimm = 1'b0;
      end
      is_b: begin
        imm32     = {{20{i[31]}}, i[7],
                     i[30:25], i[11:8], 1'b0};
        dec.fmt   = 3'd2;
        dec.noimm = 1'b0;
      end
      is_u: begin
        imm32     = {i[31:12], 12'b0};
        dec.fmt   = 3'd3;
        dec.noimm = 1'b0;
      end
      is_j: begin
        imm32     = {{12{i[31]}}, i[19:12],
                     i[20], i[30:21], 1'b0};
        dec.fmt   = 3'd4;
        dec.noimm = 1'b0;
      end
      default: ;
    endcase
    dec.imm = XLEN'(imm32);
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    cnt_nxt = cnt;
    unique case ({push, pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      noimm_cnt <= '0;
      for (int k = 0; k < DEPTH; k++)
        mem[k] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= dec;
        wptr      <= wptr + 1'b1;
        if (dec.noimm && (noimm_cnt != '1))
          noimm_cnt <= noimm_cnt + 1'b1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      cnt      <= cnt_nxt;
      // Ready is registered: a pop while full
      // frees a slot only on the next cycle.
      in_ready <= (cnt_nxt != FULL);
    end
  end

  assign head      = mem[rptr];
  assign out_valid = (cnt != '0);
  assign out_imm   = head.imm;
  assign out_fmt   = head.fmt;
  assign out_noimm = head.noimm;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe.
// Runs with CNTW=2 to reach counter saturation.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_noimm;
  logic [1:0]  noimm_cnt;

  int tests = 0;
  int fails = 0;

  imm_gen_pipe #(.XLEN(32), .DEPTH(4), .CNTW(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt),
    .out_noimm(out_noimm), .noimm_cnt(noimm_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] addi(input int k);
    return (32'(k) << 20) | 32'h0000_0093;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    int n = 0;
    in_instr = w;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: in_ready=%b want 1",
               in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    in_instr = '0;
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tests++;
    if ({out_valid, in_ready, noimm_cnt} !== 4'b0100) begin
      fails++;
      $display("FAIL reset_ctl: vld=%b rdy=%b cnt=%0d want 0 1 0",
               out_valid, in_ready, noimm_cnt);
    end
    tests++;
    if ({out_imm, out_fmt, out_noimm} !== 36'h0) begin
      fails++;
      $display("FAIL reset_head: imm=%h fmt=%0d ni=%b want 0",
               out_imm, out_fmt, out_noimm);
    end
  endtask

  task automatic test_decode();
    logic [31:0] w [7];
    logic [31:0] ei [7];
    logic [2:0]  ef [7];
    w[0] = 32'hFFF00093; ei[0] = 32'hFFFFFFFF; ef[0] = 3'd0;
    w[1] = 32'hFE000EE3; ei[1] = 32'hFFFFFFFC; ef[1] = 3'd2;
    w[2] = 32'h00C0006F; ei[2] = 32'h0000000C; ef[2] = 3'd4;
    w[3] = 32'h00112423; ei[3] = 32'h00000008; ef[3] = 3'd1;
    w[4] = 32'hFE002FA3; ei[4] = 32'hFFFFFFFF; ef[4] = 3'd1;
    w[5] = 32'h80002283; ei[5] = 32'hFFFFF800; ef[5] = 3'd0;
    w[6] = 32'h00008067; ei[6] = 32'h00000000; ef[6] = 3'd0;
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      push(w[k]);
      tests++;
      if ({out_valid, out_imm, out_fmt, out_noimm} !==
          {1'b1, ei[k], ef[k], 1'b0}) begin
        fails++;
        $display("FAIL decode_%h: v=%b imm=%h fmt=%0d ni=%b want 1 %h %0d 0",
                 w[k], out_valid, out_imm, out_fmt, out_noimm,
                 ei[k], ef[k]);
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL decode_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    bit acc = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_instr = addi(k + 1);
      @(posedge clk);
      #1;
    end
    tests++;
    if ({in_ready, out_valid, out_imm} !== {2'b01, 32'd1}) begin
      fails++;
      $display("FAIL full_flag: rdy=%b vld=%b imm=%h want 0 1 1",
               in_ready, out_valid, out_imm);
    end
    in_instr = addi(5);
    @(posedge clk);
    @(posedge clk);
    #1;
    tests++;
    if ({in_ready, out_imm} !== {1'b0, 32'd1}) begin
      fails++;
      $display("FAIL full_hold: rdy=%b imm=%h want 0 1",
               in_ready, out_imm);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 20 && got.size() < 5; n++) begin
      if (out_valid) got.push_back(out_imm);
      if (in_valid && in_ready) acc = 1;
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
    end
    tests++;
    if (got.size() != 5) begin
      fails++;
      $display("FAIL drain_count: got %0d entries want 5", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      tests++;
      if (got[k] !== 32'(k + 1)) begin
        fails++;
        $display("FAIL drain_order[%0d]: imm=%h want %h",
                 k, got[k], 32'(k + 1));
      end
    end
    tests++;
    if ({out_valid, in_valid} !== 2'b00) begin
      fails++;
      $display("FAIL drain_end: vld=%b in_valid=%b want 0 0",
               out_valid, in_valid);
    end
  endtask

  task automatic test_noimm();
    do_reset();
    out_ready = 1'b1;
    push(32'h00000033);
    tests++;
    if ({out_valid, out_imm, out_fmt, out_noimm, noimm_cnt} !==
        {1'b1, 32'h0, 3'd7, 1'b1, 2'd1}) begin
      fails++;
      $display("FAIL noimm_first: imm=%h fmt=%0d ni=%b cnt=%0d want 0 7 1 1",
               out_imm, out_fmt, out_noimm, noimm_cnt);
    end
    push(32'h00000033);
    push(32'h00000033);
    tests++;
    if (noimm_cnt !== 2'd3) begin
      fails++;
      $display("FAIL noimm_three: cnt=%0d want 3", noimm_cnt);
    end
    push(32'h00000033);
    push(32'h00000033);
    tests++;
    if (noimm_cnt !== 2'd3) begin
      fails++;
      $display("FAIL noimm_sat: cnt=%0d want 3", noimm_cnt);
    end
  endtask

  task automatic test_utype();
    logic [31:0] ei;
    logic [2:0]  ef;
    logic        en;
`ifdef IMMGEN_UTYPE_EN
    ei = 32'h12345000; ef = 3'd3; en = 1'b0;
`else
    ei = 32'h00000000; ef = 3'd7; en = 1'b1;
`endif
    out_ready = 1'b1;
    push(32'h123450B7);
    tests++;
    if ({out_imm, out_fmt, out_noimm} !== {ei, ef, en}) begin
      fails++;
      $display("FAIL lui: imm=%h fmt=%0d ni=%b want %h %0d %b",
               out_imm, out_fmt, out_noimm, ei, ef, en);
    end
    push(32'h12345097);
    tests++;
    if ({out_imm, out_fmt, out_noimm} !== {ei, ef, en}) begin
      fails++;
      $display("FAIL auipc: imm=%h fmt=%0d ni=%b want %h %0d %b",
               out_imm, out_fmt, out_noimm, ei, ef, en);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0;
    push(32'h00000033);
    push(addi(7));
    push(addi(9));
    do_reset();
    tests++;
    if ({out_valid, in_ready, noimm_cnt} !== 4'b0100) begin
      fails++;
      $display("FAIL midrst_ctl: vld=%b rdy=%b cnt=%0d want 0 1 0",
               out_valid, in_ready, noimm_cnt);
    end
    tests++;
    if ({out_imm, out_fmt, out_noimm} !== 36'h0) begin
      fails++;
      $display("FAIL midrst_head: imm=%h fmt=%0d ni=%b want 0",
               out_imm, out_fmt, out_noimm);
    end
    push(32'h00A00513);
    tests++;
    if ({out_valid, out_imm, out_fmt} !== {1'b1, 32'hA, 3'd0}) begin
      fails++;
      $display("FAIL midrst_push: vld=%b imm=%h fmt=%0d want 1 a 0",
               out_valid, out_imm, out_fmt);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_single: out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_noimm();
    test_utype();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
